// File: rtl/ps2_keyboard_rx.sv
// Host-side PS/2 keyboard receiver: frame capture, set-2 E0/F0 prefix decode, ctrl/shift tracking.
// Optional parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keyboard_rx #(
  parameter int unsigned Filter  = 3,
  parameter int unsigned Timeout = 8000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       key_clk_i,
  input  logic       key_data_i,
  output logic [7:0] data_o,
  output logic       changed_o,
  output logic [7:0] event_code_o,
  output logic       event_release_o,
  output logic       event_extended_o,
  output logic       event_valid_o,
  output logic       ctrl_o,
  output logic       shift_o,
  output logic       frame_error_o
);

  localparam int unsigned FiltW = (Filter > 1) ? $clog2(Filter) : 1;
  localparam int unsigned ToW   = $clog2(Timeout + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Input conditioning
  logic             kclk_s1_q, kclk_s2_q, kdat_s1_q, kdat_s2_q;
  logic             filt_q, filt_d, filt_prev_q;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall;

  // Frame FSM and decode state
  state_e           state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic             ext_q, ext_d, rel_q, rel_d;
  logic             parity_ok;

  logic [7:0]       data_q, data_d, code_q, code_d;
  logic             changed_q, changed_d, valid_q, valid_d;
  logic             release_q, release_d, extended_q, extended_d;
  logic             ctrl_q, ctrl_d, shift_q, shift_d, ferr_q, ferr_d;

  // The filtered clock flips once the synchronized level has disagreed for Filter cycles.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (kclk_s2_q != filt_q) begin
      if (filt_cnt_q == FiltW'(Filter - 1)) begin
        filt_d = kclk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{par_q, shreg_q};
`else
  logic unused_par;
  assign unused_par = par_q;
  assign parity_ok  = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    data_d     = data_q;
    changed_d  = 1'b0;
    code_d     = code_q;
    release_d  = release_q;
    extended_d = extended_q;
    valid_d    = 1'b0;
    ctrl_d     = ctrl_q;
    shift_d    = shift_q;
    ferr_d     = 1'b0;

    if (fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == ToW'(Timeout)) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end

    if (state_q != StIdle && to_cnt_q == ToW'(Timeout)) begin
      state_d = StIdle;
      ferr_d  = 1'b1;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!kdat_s2_q) begin
            state_d  = StData;
            bitcnt_d = '0;
          end
        end
        StData: begin
          shreg_d[bitcnt_q] = kdat_s2_q;
          bitcnt_d          = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = kdat_s2_q;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (kdat_s2_q && parity_ok) begin
            data_d    = shreg_q;
            changed_d = 1'b1;
            if (shreg_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shreg_q == 8'hF0) begin
              rel_d = 1'b1;
            end else begin
              code_d     = shreg_q;
              release_d  = rel_q;
              extended_d = ext_q;
              valid_d    = 1'b1;
              ext_d      = 1'b0;
              rel_d      = 1'b0;
              // Left/right modifiers share one flag; E0 12 is a fake shift and is ignored.
              if (shreg_q == 8'h14) begin
                ctrl_d = ~rel_q;
              end else if ((shreg_q == 8'h12 || shreg_q == 8'h59) && !ext_q) begin
                shift_d = ~rel_q;
              end
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      kclk_s1_q   <= 1'b1;
      kclk_s2_q   <= 1'b1;
      kdat_s1_q   <= 1'b1;
      kdat_s2_q   <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= StIdle;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      data_q      <= '0;
      changed_q   <= 1'b0;
      code_q      <= '0;
      release_q   <= 1'b0;
      extended_q  <= 1'b0;
      valid_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      shift_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      kclk_s1_q   <= key_clk_i;
      kclk_s2_q   <= kclk_s1_q;
      kdat_s1_q   <= key_data_i;
      kdat_s2_q   <= kdat_s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      data_q      <= data_d;
      changed_q   <= changed_d;
      code_q      <= code_d;
      release_q   <= release_d;
      extended_q  <= extended_d;
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      shift_q     <= shift_d;
      ferr_q      <= ferr_d;
    end
  end

  assign data_o           = data_q;
  assign changed_o        = changed_q;
  assign event_code_o     = code_q;
  assign event_release_o  = release_q;
  assign event_extended_o = extended_q;
  assign event_valid_o    = valid_q;
  assign ctrl_o           = ctrl_q;
  assign shift_o          = shift_q;
  assign frame_error_o    = ferr_q;

endmodule
